// File: rtl/gth_tx_scheduler.sv
// Two-channel scheduler feeding the 80-bit GTH TX word: DATA/IDLE/ALIGN framing with periodic ALIGN insertion.
// Define GTH_TX_SCHED_STATS_EN to add saturating DATA/ALIGN word counters.
module gth_tx_scheduler #(
  parameter int unsigned ALIGN_PERIOD = 256,
  parameter logic [7:0]  SYNC_DATA    = 8'hA5,
  parameter logic [7:0]  SYNC_IDLE    = 8'h1C,
  parameter logic [7:0]  SYNC_ALIGN   = 8'hBC
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        link_en,
  input  logic [63:0] p0_data,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [63:0] p1_data,
  input  logic        p1_valid,
  output logic        p1_ready,
  output logic [79:0] GTH_DATA,
  output logic        link_up
`ifdef GTH_TX_SCHED_STATS_EN
  ,
  output logic [31:0] stat_p0_cnt,
  output logic [31:0] stat_p1_cnt,
  output logic [31:0] stat_align_cnt
`endif
);

  localparam logic [79:0] IDLE_WORD  = {SYNC_IDLE, 8'h00, 64'h0};
  localparam logic [79:0] ALIGN_WORD = {SYNC_ALIGN, 8'h00, 64'h5555_5555_5555_5555};
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_PERIOD - 1);

  typedef enum logic [1:0] {DOWN, START, RUN} state_t;

  state_t      state;
  logic [15:0] align_cnt;
  logic [6:0]  seq0;
  logic [6:0]  seq1;
  logic        last_grant;
  logic        slot_open;
  logic        grant0;
  logic        grant1;

  function automatic logic [79:0] data_word(input logic ch, input logic [6:0] seq,
                                            input logic [63:0] payload);
    return {SYNC_DATA, ch, seq, payload};
  endfunction

`ifdef GTH_TX_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction
`endif

  // Readies are combinational so the source sees the grant in the cycle it is taken.
  assign slot_open = !reset && link_en && (state == RUN) && (align_cnt != ALIGN_LAST);
  assign grant0    = slot_open && p0_valid && (!p1_valid || last_grant);
  assign grant1    = slot_open && p1_valid && (!p0_valid || !last_grant);
  assign p0_ready  = grant0;
  assign p1_ready  = grant1;

  // Output stage: word, link status and all control state update together.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state      <= DOWN;
      GTH_DATA   <= IDLE_WORD;
      link_up    <= 1'b0;
      align_cnt  <= 16'd0;
      seq0       <= 7'd0;
      seq1       <= 7'd0;
      last_grant <= 1'b1;
`ifdef GTH_TX_SCHED_STATS_EN
      stat_p0_cnt    <= 32'd0;
      stat_p1_cnt    <= 32'd0;
      stat_align_cnt <= 32'd0;
`endif
    end else begin
      case (state)
        DOWN: begin
          GTH_DATA  <= IDLE_WORD;
          link_up   <= 1'b0;
          align_cnt <= 16'd0;
          if (link_en) state <= START;
        end
        START: begin
          GTH_DATA  <= ALIGN_WORD;
          align_cnt <= 16'd1;
          link_up   <= 1'b1;
          state     <= RUN;
`ifdef GTH_TX_SCHED_STATS_EN
          stat_align_cnt <= sat_inc(stat_align_cnt);
`endif
        end
        RUN: begin
          if (!link_en) begin
            GTH_DATA  <= IDLE_WORD;
            link_up   <= 1'b0;
            align_cnt <= 16'd0;
            state     <= DOWN;
          end else if (align_cnt == ALIGN_LAST) begin
            GTH_DATA  <= ALIGN_WORD;
            align_cnt <= 16'd0;
`ifdef GTH_TX_SCHED_STATS_EN
            stat_align_cnt <= sat_inc(stat_align_cnt);
`endif
          end else begin
            align_cnt <= align_cnt + 16'd1;
            if (grant0) begin
              GTH_DATA   <= data_word(1'b0, seq0, p0_data);
              seq0       <= seq0 + 7'd1;
              last_grant <= 1'b0;
`ifdef GTH_TX_SCHED_STATS_EN
              stat_p0_cnt <= sat_inc(stat_p0_cnt);
`endif
            end else if (grant1) begin
              GTH_DATA   <= data_word(1'b1, seq1, p1_data);
              seq1       <= seq1 + 7'd1;
              last_grant <= 1'b1;
`ifdef GTH_TX_SCHED_STATS_EN
              stat_p1_cnt <= sat_inc(stat_p1_cnt);
`endif
            end else begin
              GTH_DATA <= IDLE_WORD;
            end
          end
        end
        default: begin
          GTH_DATA <= IDLE_WORD;
          link_up  <= 1'b0;
          state    <= DOWN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gth_tx_scheduler.sv
// Directed bench for gth_tx_scheduler: one DUT with ALIGN_PERIOD=4, one with the default 256, shared stimulus.
module tb_gth_tx_scheduler;

  localparam logic [79:0] IDLE_W  = 80'h1C00_0000_0000_0000_0000;
  localparam logic [79:0] ALIGN_W = {8'hBC, 8'h00, 64'h5555_5555_5555_5555};

  logic        ref_clk = 1'b0;
  logic        reset = 1'b1;
  logic        link_en = 1'b0;
  logic [63:0] p0_data = 64'h0;
  logic        p0_valid = 1'b0;
  logic [63:0] p1_data = 64'h0;
  logic        p1_valid = 1'b0;

  logic [79:0] ga_data, gb_data;
  logic        ga_link, gb_link, ga_r0, ga_r1, gb_r0, gb_r1;
`ifdef GTH_TX_SCHED_STATS_EN
  logic [31:0] sa0, sa1, saa, sb0, sb1, sba;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 ref_clk = ~ref_clk;

  gth_tx_scheduler #(.ALIGN_PERIOD(4)) dut_a (
    .ref_clk(ref_clk), .reset(reset), .link_en(link_en),
    .p0_data(p0_data), .p0_valid(p0_valid), .p0_ready(ga_r0),
    .p1_data(p1_data), .p1_valid(p1_valid), .p1_ready(ga_r1),
    .GTH_DATA(ga_data), .link_up(ga_link)
`ifdef GTH_TX_SCHED_STATS_EN
    , .stat_p0_cnt(sa0), .stat_p1_cnt(sa1), .stat_align_cnt(saa)
`endif
  );

  gth_tx_scheduler #(.ALIGN_PERIOD(256)) dut_b (
    .ref_clk(ref_clk), .reset(reset), .link_en(link_en),
    .p0_data(p0_data), .p0_valid(p0_valid), .p0_ready(gb_r0),
    .p1_data(p1_data), .p1_valid(p1_valid), .p1_ready(gb_r1),
    .GTH_DATA(gb_data), .link_up(gb_link)
`ifdef GTH_TX_SCHED_STATS_EN
    , .stat_p0_cnt(sb0), .stat_p1_cnt(sb1), .stat_align_cnt(sba)
`endif
  );

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; link_en = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (ga_data !== IDLE_W || gb_data !== IDLE_W) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got %h / %h expected %h", i, ga_data, gb_data, IDLE_W);
      end
      vectors++;
      if ({ga_link, gb_link, ga_r0, ga_r1, gb_r0, gb_r1} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl cyc %0d: got %b expected 000000", i,
                 {ga_link, gb_link, ga_r0, ga_r1, gb_r0, gb_r1});
      end
    end
  endtask

  task automatic test_align_period();
    logic [79:0] exp_a, exp_b;
    do_reset();
    link_en = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_a = (e == 2 || (e >= 5 && (e - 5) % 4 == 0)) ? ALIGN_W : IDLE_W;
      exp_b = (e == 2) ? ALIGN_W : IDLE_W;
      vectors++;
      if (ga_data !== exp_a) begin
        miscompares++;
        $display("FAIL align4 word %0d: got %h expected %h", e, ga_data, exp_a);
      end
      vectors++;
      if (gb_data !== exp_b) begin
        miscompares++;
        $display("FAIL align256 word %0d: got %h expected %h", e, gb_data, exp_b);
      end
      vectors++;
      if (ga_link !== (e >= 2)) begin
        miscompares++;
        $display("FAIL link_up word %0d: got %b expected %b", e, ga_link, (e >= 2));
      end
    end
  endtask

  task automatic test_alternate();
    int          cnt;
    logic        nxt;
    logic [6:0]  s0, s1;
    logic [79:0] exp;
    logic        er0, er1;
    do_reset();
    p0_data = 64'h1111_1111_1111_1111; p1_data = 64'h2222_2222_2222_2222;
    p0_valid = 1'b1; p1_valid = 1'b1; link_en = 1'b1;
    tick(); tick();
    vectors++;
    if (gb_data !== ALIGN_W) begin
      miscompares++;
      $display("FAIL alt_start: got %h expected %h", gb_data, ALIGN_W);
    end
    cnt = 1; nxt = 1'b0; s0 = 7'd0; s1 = 7'd0;
    for (int i = 0; i < 600; i++) begin
      er0 = (cnt != 255) && !nxt;
      er1 = (cnt != 255) && nxt;
      vectors++;
      if (gb_r0 !== er0 || gb_r1 !== er1) begin
        miscompares++;
        $display("FAIL alt_ready %0d: got %b%b expected %b%b", i, gb_r0, gb_r1, er0, er1);
      end
      tick();
      if (cnt == 255) begin
        exp = ALIGN_W; cnt = 0;
      end else begin
        if (!nxt) begin exp = {8'hA5, 1'b0, s0, p0_data}; s0 = s0 + 7'd1; end
        else      begin exp = {8'hA5, 1'b1, s1, p1_data}; s1 = s1 + 7'd1; end
        nxt = ~nxt; cnt++;
      end
      vectors++;
      if (gb_data !== exp) begin
        miscompares++;
        $display("FAIL alt_word %0d: got %h expected %h", i, gb_data, exp);
      end
    end
  endtask

  task automatic test_single_p1();
    int          cnt;
    logic [6:0]  s1;
    logic [79:0] exp;
    do_reset();
    p1_data = 64'h2222_2222_2222_2222;
    p1_valid = 1'b1; link_en = 1'b1;
    tick(); tick();
    cnt = 1; s1 = 7'd0;
    for (int i = 0; i < 300; i++) begin
      vectors++;
      if (gb_r0 !== 1'b0 || gb_r1 !== (cnt != 255)) begin
        miscompares++;
        $display("FAIL p1_ready %0d: got %b%b expected 0%b", i, gb_r0, gb_r1, (cnt != 255));
      end
      tick();
      if (cnt == 255) begin
        exp = ALIGN_W; cnt = 0;
      end else begin
        exp = {8'hA5, 1'b1, s1, p1_data}; s1 = s1 + 7'd1; cnt++;
      end
      vectors++;
      if (gb_data !== exp) begin
        miscompares++;
        $display("FAIL p1_word %0d: got %h expected %h", i, gb_data, exp);
      end
    end
    p1_valid = 1'b0;
  endtask

  task automatic test_align_slot_hold();
    logic [79:0] exp;
    do_reset();
    link_en = 1'b1;
    tick(); tick(); tick(); tick();
    p0_data = 64'hDEAD_BEEF_0123_4567; p0_valid = 1'b1;
    #1;
    vectors++;
    if (ga_r0 !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ready_on_align: got %b expected 0", ga_r0);
    end
    tick();
    vectors++;
    if (ga_data !== ALIGN_W) begin
      miscompares++;
      $display("FAIL hold_align_word: got %h expected %h", ga_data, ALIGN_W);
    end
    vectors++;
    if (ga_r0 !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_ready_after: got %b expected 1", ga_r0);
    end
    tick();
    exp = {8'hA5, 1'b0, 7'd0, 64'hDEAD_BEEF_0123_4567};
    vectors++;
    if (ga_data !== exp) begin
      miscompares++;
      $display("FAIL hold_data_word: got %h expected %h", ga_data, exp);
    end
    p0_valid = 1'b0;
  endtask

  task automatic test_link_drop();
    logic [79:0] exp;
    do_reset();
    p0_data = 64'h0A0A_0A0A_0A0A_0A0A; p0_valid = 1'b1; link_en = 1'b1;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      exp = {8'hA5, 1'b0, 7'(k), p0_data};
      vectors++;
      if (gb_data !== exp) begin
        miscompares++;
        $display("FAIL drop_pre_seq %0d: got %h expected %h", k, gb_data, exp);
      end
    end
    link_en = 1'b0;
    #1;
    vectors++;
    if (gb_r0 !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ready: got %b expected 0", gb_r0);
    end
    tick();
    vectors++;
    if (gb_data !== IDLE_W || gb_link !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: got %h link %b expected %h link 0", gb_data, gb_link, IDLE_W);
    end
    tick();
    link_en = 1'b1;
    tick(); tick();
    vectors++;
    if (gb_data !== ALIGN_W) begin
      miscompares++;
      $display("FAIL relink_align: got %h expected %h", gb_data, ALIGN_W);
    end
    tick();
    exp = {8'hA5, 1'b0, 7'd5, p0_data};
    vectors++;
    if (gb_data !== exp) begin
      miscompares++;
      $display("FAIL relink_seq5: got %h expected %h", gb_data, exp);
    end
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (gb_r0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 0", gb_r0);
    end
    tick();
    vectors++;
    if (gb_data !== IDLE_W || gb_link !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got %h link %b expected %h link 0", gb_data, gb_link, IDLE_W);
    end
    reset = 1'b0;
    tick(); tick(); tick();
    exp = {8'hA5, 1'b0, 7'd0, p0_data};
    vectors++;
    if (gb_data !== exp) begin
      miscompares++;
      $display("FAIL reset_seq0: got %h expected %h", gb_data, exp);
    end
    p0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_align_period();
    test_alternate();
    test_single_p1();
    test_align_slot_hold();
    test_link_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
